alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, registered successor to the basic-computer ALU.
- Replaces the one-hot control lines ADD/DRTAC/SUB/OR/AND/XOR/COM/SHL/SHR with an encoded opcode and a start/busy/done handshake.
- Adds status flags and multi-cycle MUL/DIV.
- Sits between the DR/AC registers and the control unit; the control unit issues one op, waits for done, then loads result into AC.

Parameters:
- WIDTH, 16, data width of DR, AC, result, result_hi (minimum 4).
- CNT_W, 5, iteration counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only when busy=0
- op  in  4  opcode, sampled with start
- dr  in  WIDTH  operand DR, sampled with start
- ac  in  WIDTH  operand AC, sampled with start
- busy  out  1  high while a MUL/DIV iteration is in progress
- done  out  1  one-cycle pulse when result/flags are valid
- result  out  WIDTH  primary result (registered)
- result_hi  out  WIDTH  MUL high half / DIV remainder; 0 for other ops
- flag_c  out  1  carry
- flag_z  out  1  zero
- flag_n  out  1  negative (result MSB)
- flag_v  out  1  signed overflow
- flag_dz  out  1  divide by zero

Behaviour:
- Reset: one clock, asynchronous, active-high. Asserting rst forces state IDLE, counter 0, and all outputs 0 immediately. This applies mid-operation: an in-flight MUL/DIV is discarded and no done is produced.
- Opcodes:
  - 0 NOP
  - 1 ADD: AC+DR
  - 2 DRTAC: DR
  - 3 SUB: AC-DR
  - 4 OR
  - 5 AND
  - 6 XOR
  - 7 COM: ~AC
  - 8 SHL: AC<<1, zero fill
  - 9 SHR: AC>>1 logical
  - 10 MUL: unsigned AC*DR
  - 11 DIV: unsigned AC/DR
  - 12-15 behave as NOP
- States: IDLE, ITER.
- IDLE with start=1 and op<=9 or op>=12 (single-cycle ops):
  - result, result_hi and flags are registered on that edge (T0).
  - done=1 for the cycle after T0; state stays IDLE.
  - A new start is accepted while done is high.
- IDLE with start=1 and op=10/11:
  - Latch operands, load counter=WIDTH, go to ITER, busy=1.
  - One shift-add (MUL) or restoring-subtract (DIV) step per edge.
  - At edge T0+WIDTH: write result/result_hi/flags, pulse done, set busy=0, return to IDLE.
  - Latency from the start edge to done is WIDTH cycles.
- start while busy=1 is ignored. Operand changes during ITER have no effect.
- NOP: done pulses; result, result_hi and flags are unchanged.
- Flags:
  - Z = (result==0) for all ops except MUL, where Z = ({result_hi,result}==0).
  - N = result MSB.
  - ADD: C = carry-out; V = signed overflow.
  - SUB: C = 1 when AC>=DR (no borrow); V = signed overflow.
  - SHL: C = AC[WIDTH-1]. SHR: C = AC[0]. V=0 for both.
  - DRTAC/logic/COM/MUL/DIV: C=0, V=0.
  - flag_dz = 1 only for DIV with DR=0; cleared by any other completed op.
- DIV with DR=0: still takes WIDTH cycles. Result = all ones, result_hi = AC, dz=1.
- Width rules: ADD/SUB are computed at WIDTH+1 bits for carry. The MUL product is 2*WIDTH, split low/high.

Decomposition:
- Shared header alu_defs.vh: opcode localparams (OP_NOP..OP_DIV) and the state encodings.
- One sub-module, alu_muldiv_core:
  - Holds the iterative multiply/divide datapath and counter.
  - Interface: go, is_div, a, b, busy, fin, lo, hi, dz.
- The top level keeps the single-cycle datapath, the flags and the handshake.

Test Plan (WIDTH=16):
1. ADD ac=0x1111 dr=0x1111 -> result 0x2222, C=0 Z=0 N=0 V=0, done one cycle after start. Then SUB ac=0x3333 dr=0x1111 -> 0x2222, C=1.
2. ADD ac=0x7FFF dr=0x0001 -> 0x8000, V=1 N=1 C=0. Then SUB ac=0x0000 dr=0x0001 -> 0xFFFF, C=0 N=1.
3. OR 0x1111|0x2211 -> 0x3311; AND 0x1111&0x0011 -> 0x0011; XOR 0x1111^0x1001 -> 0x0110; COM 0x1111 -> 0xEEEE; SHL 0x8111 -> 0x0222 C=1; SHR 0x1111 -> 0x0888 C=1.
4. MUL ac=0x0123 dr=0x0100 -> result 0x2300, result_hi 0x0001, busy high for 16 cycles, done exactly 16 edges after the start edge. A second start issued mid-op is ignored.
5. DIV ac=0x0064 dr=0x0007 -> result 0x000E, result_hi 0x0002, dz=0. DIV ac=0x1111 dr=0x0000 -> result 0xFFFF, result_hi 0x1111, dz=1.
6. Assert rst during cycle 8 of a MUL -> all outputs 0 immediately, no done pulse. After release, ADD 0x0001+0x0001 -> 0x0002 normally.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared opcode encodings, FSM states and flag bundle for the
// alu_seq block and its iterative multiply/divide core.
package alu_seq_pkg;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_ADD   = 4'd1;
    localparam logic [3:0] OP_DRTAC = 4'd2;
    localparam logic [3:0] OP_SUB   = 4'd3;
    localparam logic [3:0] OP_OR    = 4'd4;
    localparam logic [3:0] OP_AND   = 4'd5;
    localparam logic [3:0] OP_XOR   = 4'd6;
    localparam logic [3:0] OP_COM   = 4'd7;
    localparam logic [3:0] OP_SHL   = 4'd8;
    localparam logic [3:0] OP_SHR   = 4'd9;
    localparam logic [3:0] OP_MUL   = 4'd10;
    localparam logic [3:0] OP_DIV   = 4'd11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ITER = 1'b1
    } state_e;

    typedef struct packed {
        logic c;
        logic z;
        logic n;
        logic v;
        logic dz;
    } flags_t;

    // MUL and DIV run through the iterative core; every other code
    // (including the undefined 12-15) completes in one cycle.
    function automatic logic is_iter_op(input logic [3:0] o);
        return (o == OP_MUL) || (o == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_muldiv_core.sv
// alu_muldiv_core: iterative unsigned multiply (shift-add) and divide
// (restoring), one step per clock, WIDTH steps per operation.
//   go     : load operands and start (ignored by caller while busy)
//   is_div : 1 = divide a/b, 0 = multiply a*b
//   a, b   : operands (a = multiplier / dividend, b = multiplicand / divisor)
//   busy   : iteration in progress
//   fin    : the current cycle performs the last step
//   lo, hi : value the working registers take on this edge; when fin is high
//            these are the final product low/high or quotient/remainder
//   dz     : divide with b == 0
import alu_seq_pkg::*;

module alu_muldiv_core #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             fin,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi,
    output logic             dz
);

    logic             busy_q;
    logic             div_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] b_q;

    logic [WIDTH:0]   mul_sum;
    logic             div_ge;
    logic [WIDTH-1:0] div_shift;

    always_comb begin
        // Multiply: hi accumulates, lo holds the remaining multiplier bits
        // and collects product bits shifted out of hi.
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        // Divide: shift the next dividend bit into the partial remainder;
        // the compare needs WIDTH+1 bits since the shifted value may exceed b.
        div_shift = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
        div_ge    = ({1'b0, hi_q, lo_q[WIDTH-1]} >= {2'b00, b_q});
        if (div_q) begin
            // With b == 0 every trial succeeds, which naturally leaves an
            // all-ones quotient and the dividend as remainder.
            hi = div_ge ? (div_shift - b_q) : div_shift;
            lo = {lo_q[WIDTH-2:0], div_ge};
        end else begin
            hi = mul_sum[WIDTH:1];
            lo = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= 1'b0;
            div_q  <= 1'b0;
            cnt_q  <= '0;
            lo_q   <= '0;
            hi_q   <= '0;
            b_q    <= '0;
        end else if (go) begin
            busy_q <= 1'b1;
            div_q  <= is_div;
            cnt_q  <= CNT_W'(WIDTH);
            lo_q   <= a;
            hi_q   <= '0;
            b_q    <= b;
        end else if (busy_q) begin
            lo_q  <= lo;
            hi_q  <= hi;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) busy_q <= 1'b0;
        end
    end

    assign busy = busy_q;
    assign fin  = busy_q && (cnt_q == CNT_W'(1));
    assign dz   = div_q && (b_q == '0);

endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with start/busy/done handshake. Single-cycle ops
// complete on the start edge (done the following cycle); MUL/DIV run WIDTH
// cycles in alu_muldiv_core.
//   clk, rst          : clock, asynchronous active-high reset
//   start, op, dr, ac : request, sampled only when not busy
//   busy              : MUL/DIV iteration in progress
//   done              : one-cycle pulse, result/flags valid
//   result, result_hi : primary result; MUL high half / DIV remainder
//   flag_c/z/n/v/dz   : carry, zero, negative, overflow, divide-by-zero
import alu_seq_pkg::*;

module alu_seq #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] dr,
    input  logic [WIDTH-1:0] ac,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             flag_c,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_v,
    output logic             flag_dz
);

    localparam int M = WIDTH - 1;

    state_e           state_q, state_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    flags_t           flags_q, flags_d;

    logic             go;
    logic             md_busy, md_fin, md_dz;
    logic [WIDTH-1:0] md_lo, md_hi;

    logic [WIDTH:0]   sum, diff;
    logic [WIDTH-1:0] sc_res;
    logic             sc_c, sc_v, sc_upd;

    alu_muldiv_core #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_md (
        .clk    (clk),
        .rst    (rst),
        .go     (go),
        .is_div (op == OP_DIV),
        .a      (ac),
        .b      (dr),
        .busy   (md_busy),
        .fin    (md_fin),
        .lo     (md_lo),
        .hi     (md_hi),
        .dz     (md_dz)
    );

    // Single-cycle datapath; ADD/SUB carry comes from the extra top bit.
    always_comb begin
        sum    = {1'b0, ac} + {1'b0, dr};
        diff   = {1'b0, ac} - {1'b0, dr};
        sc_res = '0;
        sc_c   = 1'b0;
        sc_v   = 1'b0;
        sc_upd = 1'b1;
        case (op)
            OP_ADD: begin
                sc_res = sum[M:0];
                sc_c   = sum[WIDTH];
                sc_v   = (ac[M] == dr[M]) && (sum[M] != ac[M]);
            end
            OP_DRTAC: sc_res = dr;
            OP_SUB: begin
                sc_res = diff[M:0];
                sc_c   = ~diff[WIDTH];  // no borrow: ac >= dr
                sc_v   = (ac[M] != dr[M]) && (diff[M] != ac[M]);
            end
            OP_OR:  sc_res = ac | dr;
            OP_AND: sc_res = ac & dr;
            OP_XOR: sc_res = ac ^ dr;
            OP_COM: sc_res = ~ac;
            OP_SHL: begin
                sc_res = {ac[M-1:0], 1'b0};
                sc_c   = ac[M];
            end
            OP_SHR: begin
                sc_res = {1'b0, ac[M:1]};
                sc_c   = ac[0];
            end
            default: sc_upd = 1'b0;  // NOP and 12-15 leave state untouched
        endcase
    end

    always_comb begin
        state_d  = state_q;
        done_d   = 1'b0;
        result_d = result_q;
        hi_d     = hi_q;
        flags_d  = flags_q;
        go       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (is_iter_op(op)) begin
                        go      = 1'b1;
                        state_d = ST_ITER;
                    end else begin
                        done_d = 1'b1;
                        if (sc_upd) begin
                            result_d   = sc_res;
                            hi_d       = '0;
                            flags_d.c  = sc_c;
                            flags_d.z  = (sc_res == '0);
                            flags_d.n  = sc_res[M];
                            flags_d.v  = sc_v;
                            flags_d.dz = 1'b0;
                        end
                    end
                end
            end
            ST_ITER: begin
                if (md_fin) begin
                    state_d    = ST_IDLE;
                    done_d     = 1'b1;
                    result_d   = md_lo;
                    hi_d       = md_hi;
                    flags_d.c  = 1'b0;
                    flags_d.v  = 1'b0;
                    flags_d.n  = md_lo[M];
                    flags_d.dz = md_dz;
                    // MUL zero covers the full double-width product.
                    flags_d.z  = md_dz || u_md.div_q ? (md_lo == '0)
                                                     : ({md_hi, md_lo} == '0);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            done_q   <= 1'b0;
            result_q <= '0;
            hi_q     <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            done_q   <= done_d;
            result_q <= result_d;
            hi_q     <= hi_d;
            flags_q  <= flags_d;
        end
    end

    assign busy      = md_busy;
    assign done      = done_q;
    assign result    = result_q;
    assign result_hi = hi_q;
    assign flag_c    = flags_q.c;
    assign flag_z    = flags_q.z;
    assign flag_n    = flags_q.n;
    assign flag_v    = flags_q.v;
    assign flag_dz   = flags_q.dz;

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [3:0]   op;
    logic [W-1:0] dr, ac;
    logic         busy, done;
    logic [W-1:0] result, result_hi;
    logic         flag_c, flag_z, flag_n, flag_v, flag_dz;

    alu_seq #(.WIDTH(W), .CNT_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .dr        (dr),
        .ac        (ac),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .result_hi (result_hi),
        .flag_c    (flag_c),
        .flag_z    (flag_z),
        .flag_n    (flag_n),
        .flag_v    (flag_v),
        .flag_dz   (flag_dz)
    );

    always #5 clk = ~clk;

    // flags packed as {c, z, n, v, dz}
    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] ac;
        logic [W-1:0] dr;
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic [4:0]   fl;
    } vec_t;

    typedef struct {
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic [4:0]   fl;
        int           tag;
    } exp_t;

    vec_t tbl[16];
    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    wire [4:0] fl_now = {flag_c, flag_z, flag_n, flag_v, flag_dz};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboard consumer: every done pulse must match the oldest pending op.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_done: got done=1 expected no pending op");
            end else begin
                mon_e = sb.pop_front();
                chk($sformatf("result[%0d]", mon_e.tag), 64'(result), 64'(mon_e.res));
                chk($sformatf("result_hi[%0d]", mon_e.tag), 64'(result_hi), 64'(mon_e.hi));
                chk($sformatf("flags[%0d]", mon_e.tag), 64'(fl_now), 64'(mon_e.fl));
            end
        end
    end

    // Issue a MUL/DIV and check latency, busy length and that a start
    // (with changed operands) during the iteration is ignored.
    task automatic muldiv(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] d,
                          input logic [W-1:0] er, input logic [W-1:0] eh,
                          input logic [4:0] ef, input int tag);
        int lat;
        int bcnt;
        exp_t e;
        e.res = er; e.hi = eh; e.fl = ef; e.tag = tag;
        op = o; ac = a; dr = d; start = 1'b1;
        sb.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        bcnt = busy ? 1 : 0;
        lat = 0;
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            if (k == 3) begin op = 4'd1; ac = 16'h0001; dr = 16'h0001; start = 1'b1; end
            if (k == 4) start = 1'b0;
            @(posedge clk); #1;
            if (done) begin
                lat = k;
                chk($sformatf("busy_at_done[%0d]", tag), 64'(busy), 64'd0);
            end else if (busy) begin
                bcnt++;
            end
        end
        start = 1'b0;
        chk($sformatf("latency[%0d]", tag), 64'(lat), 64'(W));
        chk($sformatf("busy_cycles[%0d]", tag), 64'(bcnt), 64'(W));
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int dcnt;
        exp_t e;
        //            op     ac        dr        res       hi    {c,z,n,v,dz}
        tbl[0]  = '{4'd1,  16'h1111, 16'h1111, 16'h2222, 16'h0, 5'b00000};
        tbl[1]  = '{4'd3,  16'h3333, 16'h1111, 16'h2222, 16'h0, 5'b10000};
        tbl[2]  = '{4'd1,  16'h7FFF, 16'h0001, 16'h8000, 16'h0, 5'b00110};
        tbl[3]  = '{4'd3,  16'h0000, 16'h0001, 16'hFFFF, 16'h0, 5'b00100};
        tbl[4]  = '{4'd4,  16'h1111, 16'h2211, 16'h3311, 16'h0, 5'b00000};
        tbl[5]  = '{4'd5,  16'h1111, 16'h0011, 16'h0011, 16'h0, 5'b00000};
        tbl[6]  = '{4'd6,  16'h1111, 16'h1001, 16'h0110, 16'h0, 5'b00000};
        tbl[7]  = '{4'd7,  16'h1111, 16'h5555, 16'hEEEE, 16'h0, 5'b00100};
        tbl[8]  = '{4'd8,  16'h8111, 16'h0000, 16'h0222, 16'h0, 5'b10000};
        tbl[9]  = '{4'd9,  16'h1111, 16'h0000, 16'h0888, 16'h0, 5'b10000};
        tbl[10] = '{4'd2,  16'h0000, 16'hABCD, 16'hABCD, 16'h0, 5'b00100};
        tbl[11] = '{4'd0,  16'h0001, 16'h0001, 16'hABCD, 16'h0, 5'b00100};
        tbl[12] = '{4'd1,  16'hFFFF, 16'h0001, 16'h0000, 16'h0, 5'b11000};
        tbl[13] = '{4'd13, 16'h1234, 16'h4321, 16'h0000, 16'h0, 5'b11000};
        tbl[14] = '{4'd3,  16'h8000, 16'h0001, 16'h7FFF, 16'h0, 5'b10010};
        tbl[15] = '{4'd5,  16'h0F0F, 16'hF0F0, 16'h0000, 16'h0, 5'b01000};

        rst = 1'b1; start = 1'b0; op = '0; dr = '0; ac = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", 64'({busy, done, result, result_hi, fl_now}), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Back-to-back single-cycle ops: each start is taken while the
        // previous done is still high.
        for (int i = 0; i < 16; i++) begin
            op = tbl[i].op; ac = tbl[i].ac; dr = tbl[i].dr; start = 1'b1;
            e.res = tbl[i].res; e.hi = tbl[i].hi; e.fl = tbl[i].fl; e.tag = i;
            sb.push_back(e);
            @(posedge clk); #1;
            chk($sformatf("done_after_start[%0d]", i), 64'(done), 64'd1);
        end
        start = 1'b0;
        @(posedge clk); #1;
        chk("done_one_pulse", 64'(done), 64'd0);

        muldiv(4'd10, 16'h0123, 16'h0100, 16'h2300, 16'h0001, 5'b00000, 100);
        muldiv(4'd11, 16'h0064, 16'h0007, 16'h000E, 16'h0002, 5'b00000, 101);
        muldiv(4'd11, 16'h1111, 16'h0000, 16'hFFFF, 16'h1111, 5'b00101, 102);
        muldiv(4'd10, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 5'b00000, 103);
        muldiv(4'd10, 16'h8000, 16'h0002, 16'h0000, 16'h0001, 5'b00000, 104);
        muldiv(4'd10, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 5'b01000, 105);
        muldiv(4'd11, 16'h0005, 16'h0009, 16'h0000, 16'h0005, 5'b01000, 106);
        // leave non-zero outputs behind for the reset check
        muldiv(4'd11, 16'h1111, 16'h0000, 16'hFFFF, 16'h1111, 5'b00101, 107);

        // Reset in cycle 8 of a MUL: outputs clear at once, no done follows.
        op = 4'd10; ac = 16'h00FF; dr = 16'h00FF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("reset_mid_mul", 64'({busy, done, result, result_hi, fl_now}), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        dcnt = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done) dcnt++;
        end
        chk("no_done_after_reset", 64'(dcnt), 64'd0);

        op = 4'd1; ac = 16'h0001; dr = 16'h0001; start = 1'b1;
        e.res = 16'h0002; e.hi = 16'h0; e.fl = 5'b00000; e.tag = 200;
        sb.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        chk("done_after_reset_add", 64'(done), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
